// File: rtl/cam_cfg_seq_pkg.sv
// Shared types and constants for the camera register-load sequencer.
// Table entry layout, control-marker addresses and default sizing.
package cam_cfg_seq_pkg;

  localparam logic [6:0]  DEF_I2C_SLAVE_ADDR = 7'h10;
  localparam int          DEF_NUM_REGISTERS  = 64;
  localparam int          DEF_MAX_RETRY      = 3;

  localparam logic [15:0] CFG_ADDR_DELAY = 16'hFFFF;
  localparam logic [15:0] CFG_ADDR_END   = 16'hFFFE;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } cfg_entry_t;

endpackage

// File: rtl/cam_cfg_seq_dly.sv
// Millisecond delay counter for DELAY table entries.
// Ports: clk/areset_n, i_load+i_ms load ms*MS_CYC, i_run counts, o_last.
module cam_cfg_seq_dly #(
  parameter  int MS_CYC = 100_000,
  localparam int CNT_W  = $clog2(255 * MS_CYC + 1)
) (
  input  logic       clk,
  input  logic       areset_n,
  input  logic       i_load,
  input  logic [7:0] i_ms,
  input  logic       i_run,
  output logic       o_last
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CNT_W'(i_ms) * CNT_W'(MS_CYC);
    end else if (i_run && r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Exit on the cycle holding 1 so DELAY lasts exactly ms*MS_CYC cycles.
  assign o_last = (r_cnt <= CNT_W'(1));

endmodule

// File: rtl/cam_cfg_seq.sv
// Camera config sequencer: walks a {addr,data} table and issues I2C writes.
// Ports: start, cfg_rd_idx/entry (ROM), i2c_req_*, i2c_rsp_*, busy/done/error.
module cam_cfg_seq
  import cam_cfg_seq_pkg::*;
#(
  parameter  logic [6:0] I2C_SLAVE_ADDR = DEF_I2C_SLAVE_ADDR,
  parameter  int         NUM_REGISTERS  = DEF_NUM_REGISTERS,
  parameter  int         MAX_RETRY      = DEF_MAX_RETRY,
  parameter  int         CLK_FREQ_HZ    = 100_000_000,
  localparam int         IDX_W          = $clog2(NUM_REGISTERS)
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             start,
  output logic [IDX_W-1:0] cfg_rd_idx,
  input  logic [23:0]      cfg_rd_entry,
  output logic             i2c_req_vld,
  input  logic             i2c_req_rdy,
  output logic [6:0]       i2c_req_dev,
  output logic [15:0]      i2c_req_reg,
  output logic [7:0]       i2c_req_dat,
  input  logic             i2c_rsp_vld,
  input  logic             i2c_rsp_nack,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [IDX_W-1:0] err_idx
);

  localparam int MS_CYC = CLK_FREQ_HZ / 1000;
  localparam int RTY_W  = $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, ISSUE,
    WAIT_RSP, DELAY, DONE, ERROR
  } cfg_state_t;

  cfg_state_t       r_state;
  cfg_state_t       w_state_n;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_n;
  logic [RTY_W-1:0] r_rty;
  logic [RTY_W-1:0] w_rty_n;
  logic [IDX_W-1:0] r_err_idx;
  logic [IDX_W-1:0] w_err_idx_n;
  cfg_entry_t       r_ent;
  cfg_entry_t       w_ent;
  logic [6:0]       r_dev;
  logic             r_vld;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic             w_vld_n;
  logic             w_busy_n;
  logic             w_adv;
  logic             w_load;
  logic             w_dly_run;
  logic             w_dly_last;

  assign w_ent     = cfg_rd_entry;
  assign w_dly_run = (r_state == DELAY);

  cam_cfg_seq_dly #(
    .MS_CYC (MS_CYC)
  ) u_dly (
    .clk      (clk),
    .areset_n (areset_n),
    .i_load   (w_load),
    .i_ms     (w_ent.data),
    .i_run    (w_dly_run),
    .o_last   (w_dly_last)
  );

  always_comb begin
    w_state_n   = r_state;
    w_idx_n     = r_idx;
    w_rty_n     = r_rty;
    w_err_idx_n = r_err_idx;
    w_adv       = 1'b0;
    w_load      = 1'b0;
    unique case (r_state)
      IDLE, DONE, ERROR: begin
        if (start) begin
          w_state_n   = FETCH;
          w_idx_n     = '0;
          w_rty_n     = '0;
          w_err_idx_n = '0;
        end
      end
      FETCH: w_state_n = DECODE;
      DECODE: begin
        if (w_ent.addr == CFG_ADDR_END) begin
          w_state_n = DONE;
        end else if (w_ent.addr == CFG_ADDR_DELAY) begin
          if (w_ent.data == 8'd0) begin
            w_adv = 1'b1;
          end else begin
            w_load    = 1'b1;
            w_state_n = DELAY;
          end
        end else begin
          w_state_n = ISSUE;
        end
      end
      ISSUE: begin
        if (i2c_req_rdy) w_state_n = WAIT_RSP;
      end
      WAIT_RSP: begin
        if (i2c_rsp_vld) begin
          if (!i2c_rsp_nack) begin
            w_adv = 1'b1;
          end else if ((32'(r_rty) + 32'd1) < 32'(MAX_RETRY)) begin
            w_rty_n   = r_rty + RTY_W'(1);
            w_state_n = ISSUE;
          end else begin
            w_err_idx_n = r_idx;
            w_state_n   = ERROR;
          end
        end
      end
      DELAY: begin
        if (w_dly_last) w_adv = 1'b1;
      end
      default: w_state_n = IDLE;
    endcase

    if (w_adv) begin
      w_rty_n = '0;
      if (r_idx == IDX_W'(NUM_REGISTERS - 1)) begin
        w_state_n = DONE;
      end else begin
        w_idx_n   = r_idx + IDX_W'(1);
        w_state_n = FETCH;
      end
    end

    w_vld_n  = (w_state_n == ISSUE);
    w_busy_n = !(w_state_n inside {IDLE, DONE, ERROR});
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_rty     <= '0;
      r_err_idx <= '0;
      r_ent     <= '0;
      r_dev     <= '0;
      r_vld     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_idx     <= w_idx_n;
      r_rty     <= w_rty_n;
      r_err_idx <= w_err_idx_n;
      if (r_state == DECODE) begin
        r_ent <= w_ent;
        r_dev <= I2C_SLAVE_ADDR;
      end
      r_vld  <= w_vld_n;
      r_busy <= w_busy_n;
      r_done <= (w_state_n == DONE);
      r_err  <= (w_state_n == ERROR);
    end
  end

  assign cfg_rd_idx  = r_idx;
  assign i2c_req_vld = r_vld;
  assign i2c_req_dev = r_dev;
  assign i2c_req_reg = r_ent.addr;
  assign i2c_req_dat = r_ent.data;
  assign busy        = r_busy;
  assign done        = r_done;
  assign error       = r_err;
  assign err_idx     = r_err_idx;

endmodule

// File: doc/cam_cfg_seq.md
# cam_cfg_seq

Camera register-load sequencer for the I2C configuration path. It sits directly upstream of the byte-level I2C master inside the I2C subsystem, in the `clk_100` domain.

- Walks a table of `{reg_addr[15:0], data[7:0]}` entries and issues one 16-bit-address register write per entry over a valid/ready request channel.
- Handles NACK retries, millisecond delay entries and an early end marker.
- Reports `busy`/`done`/`error` so the camera-enable and CSI logic can wait for a configured sensor.

## Interface
Parameters:
- `I2C_SLAVE_ADDR`, default 7'h10: 7-bit device address driven on every request.
- `NUM_REGISTERS`, default 64: table depth; index width is `IDX_W = $clog2(NUM_REGISTERS)`.
- `MAX_RETRY`, default 3: NACKed attempts allowed per entry before error.
- `CLK_FREQ_HZ`, default 100_000_000: used to derive `MS_CYC = CLK_FREQ_HZ/1000`.

Ports:
- `clk`, in, 1: single clock (100 MHz).
- `areset_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: single-cycle pulse that begins a load.
- `cfg_rd_idx`, out, IDX_W: table read index.
- `cfg_rd_entry`, in, 24: table word `{addr, data}`; synchronous ROM, valid 1 cycle after `cfg_rd_idx`.
- `i2c_req_vld`, out, 1: write request valid.
- `i2c_req_rdy`, in, 1: master accepts the request.
- `i2c_req_dev`, out, 7: device address (= `I2C_SLAVE_ADDR`).
- `i2c_req_reg`, out, 16: register address.
- `i2c_req_dat`, out, 8: register data.
- `i2c_rsp_vld`, in, 1: single-cycle transaction-complete pulse.
- `i2c_rsp_nack`, in, 1: qualifies `i2c_rsp_vld`; 1 = NACK at any byte.
- `busy`, out, 1: load in progress.
- `done`, out, 1: level; table fully written.
- `error`, out, 1: level; retries exhausted.
- `err_idx`, out, IDX_W: index of the failing entry.

## Operation
- **Reset values:** all outputs 0; FSM in `IDLE`; index, retry counter and delay counter at 0.
- **FSM states:** `IDLE`, `FETCH`, `DECODE`, `ISSUE`, `WAIT_RSP`, `DELAY`, `DONE`, `ERROR`.
- **Starting:**
  - `IDLE`, `DONE` or `ERROR` with `start`=1 → `FETCH`. This clears `done`, `error`, `err_idx`, the index and the retry counter.
  - `start` is ignored while `busy`.
- **`FETCH`:** drives `cfg_rd_idx`; 1 cycle; → `DECODE`.
- **`DECODE`:** registers the entry, then branches on `addr`:
  - `addr` == 16'hFFFE (END): → `DONE`.
  - `addr` == 16'hFFFF (DELAY): load delay counter with `data*MS_CYC`, → `DELAY`. `data` = 0 gives 0 wait cycles, → advance.
  - Otherwise → `ISSUE`.
- **`ISSUE`:**
  - `i2c_req_vld`=1 with `dev`/`reg`/`dat` stable.
  - `vld` stays high and the payload stays unchanged until `i2c_req_rdy`.
  - Handshake cycle → `WAIT_RSP`; `vld` drops the following cycle.
- **`WAIT_RSP`:** waits for `i2c_rsp_vld`.
  - ACK → advance.
  - NACK with retry count + 1 < `MAX_RETRY` → increment retry count, → `ISSUE`.
  - NACK otherwise → `ERROR` with `err_idx` = current index.
- **`DELAY`:** decrement each cycle; at 0 → advance.
- **Advance:** clear retry count. If index == `NUM_REGISTERS-1` → `DONE`, else index+1 → `FETCH`.
- **Status outputs:**
  - `busy`=1 in every state except `IDLE`, `DONE` and `ERROR`.
  - `done` and `error` are registered levels and are mutually exclusive.
- **Boundary conditions:**
  - `i2c_rsp_vld` outside `WAIT_RSP` is ignored.
  - `i2c_req_rdy` outside `ISSUE` is ignored.
  - `areset_n` asserted mid-load aborts immediately: `vld` drops asynchronously, and no further request is issued until a new `start`.
  - A response and `start` arriving in the same cycle: the response is processed and `start` is dropped.

## Timing
- Output ports are driven from registers only; there is no combinational path from the `rdy`/`rsp` inputs to the outputs.
- `start` → `i2c_req_vld`: 3 cycles (`FETCH`, `DECODE`, `ISSUE`).
- ACK → next `i2c_req_vld`: 3 cycles (advance, `FETCH`, `DECODE`).
- DELAY entry with `data`=N: exactly `N*MS_CYC` cycles spent in `DELAY`.
- Delay counter width: `$clog2(255*MS_CYC+1)`, i.e. 25 bits at 100 MHz. `data*MS_CYC` is computed at this width with no truncation.

## Structure
- **`top_pkg` additions:**
  - `typedef struct packed {logic [15:0] addr; logic [7:0] data;} cfg_entry_t`
  - `CFG_ADDR_DELAY` = 16'hFFFF
  - `CFG_ADDR_END` = 16'hFFFE
  - `I2C_SLAVE_ADDR` and `NUM_REGISTERS` are already present.
- **FSM encoding:** state enum `cfg_state_t` is local to the module.
- **Companion ROM:** `cam_cfg_rom`, a synchronous ROM of `cfg_entry_t` with 1-cycle latency.
  - Instantiated alongside this block within `i2c_top`, not inside it.
  - Keeping it outside lets the bench substitute the table.

## Test plan
- **Plain load:** table of 4 writes (0x0100←0x00, 0x0103←0x01, 0x0114←0x01, 0x0100←0x01), `rdy` always 1, all ACK.
  - Required: 4 requests in order with `dev`=0x10.
  - Required: `done`=1 after the 4th ACK; `busy` high throughout.
  - Required: first `vld` 3 cycles after `start`.
- **Backpressure:** `rdy` held 0 for 7 cycles.
  - Required: `vld` stays high and the payload is unchanged.
  - Required: exactly one handshake per entry.
- **NACK retry:** entry 2 NACKs twice then ACKs, `MAX_RETRY`=3.
  - Required: 3 requests for entry 2, then `done`=1.
  - Variant: 3 NACKs → `error`=1, `err_idx`=2, no further requests.
- **Delay and end marker:** entries {0xFFFF, 0x05}, {0xFFFE, x}, `MS_CYC` = 100 (bench override).
  - Required: 500 idle cycles, then `done` with zero requests issued.
  - Variant: `data`=0 → no idle cycles.
- **Reset and restart:** `areset_n` pulsed low while in `WAIT_RSP`.
  - Required: all outputs 0 during reset; a late `rsp_vld` is ignored.
  - Required: a new `start` reloads from index 0.
  - Required: `start` while `busy` has no effect.
